// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions,
// operand selects, flag bit positions and the filter FSM states.
package exe_pkg;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 6;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASSB, ALU_FILT
  } alu_op_e;

  typedef enum logic [1:0] {CND_AL, CND_EQ, CND_NE, CND_LT} cond_e;

  localparam logic [1:0] SEL_REG = 2'd0, SEL_MEM = 2'd1, SEL_WB = 2'd2, SEL_ALT = 2'd3;

  localparam int FN = 3, FZ = 2, FC = 1, FV = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mac_st_e;

  function automatic logic cond_true(input logic [1:0] c, input logic [3:0] f);
    case (cond_e'(c))
      CND_AL:  return 1'b1;
      CND_EQ:  return f[FZ];
      CND_NE:  return !f[FZ];
      default: return f[FN] ^ f[FV];
    endcase
  endfunction
endpackage

// File: rtl/exe_pixel_mac.sv
// Lane-serial weighted-sum filter: one pixel*coef per RUN cycle, then
// arithmetic shift and clamp to 0..255 presented during DONE.
module exe_pixel_mac
  import exe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int VW    = 40,
  parameter int LANES = 5,
  parameter int ACCW  = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [VW-1:0] i_pix,
  input  logic [DW-1:0] i_coef,
  output mac_st_e       o_state,
  output logic [7:0]    o_res
);
  mac_st_e                   r_state, w_nxt;
  logic [2:0]                r_cnt;
  logic [VW-1:0]             r_pix;
  logic [COEF_W*LANES-1:0]   r_coef;
  logic [1:0]                r_shamt;
  logic signed [ACCW-1:0]    r_acc;
  logic [ACCW-1:0]           w_pe, w_ke, w_prod;
  logic signed [ACCW-1:0]    w_sh;

  // Operands are consumed from the low end; the capture registers shift each lane.
  assign w_pe   = {{(ACCW-PIX_W){1'b0}}, r_pix[PIX_W-1:0]};
  assign w_ke   = {{(ACCW-COEF_W){r_coef[COEF_W-1]}}, r_coef[COEF_W-1:0]};
  assign w_prod = w_pe * w_ke;
  assign w_sh   = r_acc >>> r_shamt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == 3'(LANES-1)) w_nxt = ST_DONE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pix   <= '0;
      r_coef  <= '0;
      r_shamt <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_IDLE && i_start) begin
        r_pix   <= i_pix;
        r_coef  <= i_coef[COEF_W*LANES-1:0];
        r_shamt <= i_coef[DW-1 -: 2];
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc  <= r_acc + $signed(w_prod);
        r_cnt  <= r_cnt + 3'd1;
        r_pix  <= r_pix >> PIX_W;
        r_coef <= r_coef >> COEF_W;
      end
    end
  end

  assign o_state = r_state;
  assign o_res   = w_sh[ACCW-1] ? 8'h00 : (|w_sh[ACCW-2:8]) ? 8'hFF : w_sh[7:0];
endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU and flags, branch resolution,
// filter sequencing and the execute->memory output register.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int VW    = 40,
  parameter int LANES = 5,
  parameter int ACCW  = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cond,
  input  logic          we_mem,
  input  logic          sel_dat,
  input  logic          sel_res,
  input  logic          sel_c,
  input  logic          we_v,
  input  logic          we_c_aux,
  input  logic          compara,
  input  logic          suma_resta,
  input  logic          salto,
  input  logic          PROHIB_EXE,
  input  logic [2:0]    ALU_CTRL,
  input  logic [1:0]    selOp_A,
  input  logic [1:0]    selOp_B,
  input  logic [DW-1:0] PCmas4,
  input  logic [DW-1:0] DoA,
  input  logic [DW-1:0] DoB,
  input  logic [DW-1:0] inmediato,
  input  logic [VW-1:0] cuarenta,
  input  logic [3:0]    Rg_exe,
  input  logic [DW-1:0] fwd_mem,
  input  logic [DW-1:0] fwd_wb,
  output logic          stall_o,
  output logic          br_taken_o,
  output logic [DW-1:0] br_target_o,
  output logic [3:0]    flags_o,
  output logic [DW-1:0] alu_res_o,
  output logic [DW-1:0] st_data_o,
  output logic          we_mem_o,
  output logic          sel_dat_o,
  output logic          sel_res_o,
  output logic [3:0]    Rg_o,
  output logic          valid_o
);
  logic [DW-1:0] w_a, w_b, w_bx, w_alu;
  logic [DW:0]   w_sum;
  logic          w_sub, w_cin, w_ovf;
  logic          w_filt, w_idle, w_start, w_scal, w_arch;
  logic [3:0]    r_flags;
  mac_st_e       w_mst;
  logic [7:0]    w_fres;

  always_comb begin
    case (selOp_A)
      SEL_REG: w_a = DoA;
      SEL_MEM: w_a = fwd_mem;
      SEL_WB:  w_a = fwd_wb;
      default: w_a = PCmas4;
    endcase
    case (selOp_B)
      SEL_REG: w_b = DoB;
      SEL_MEM: w_b = fwd_mem;
      SEL_WB:  w_b = fwd_wb;
      default: w_b = inmediato;
    endcase
  end

  // Subtract is A + ~B + 1; with sel_c the stored carry (no-borrow) replaces the +1.
  assign w_sub = suma_resta | compara;
  assign w_bx  = w_sub ? ~w_b : w_b;
  assign w_cin = sel_c ? r_flags[FC] : w_sub;
  assign w_sum = {1'b0, w_a} + {1'b0, w_bx} + {{DW{1'b0}}, w_cin};
  assign w_ovf = (w_a[DW-1] == w_bx[DW-1]) && (w_sum[DW-1] != w_a[DW-1]);

  always_comb begin
    case (alu_op_e'(ALU_CTRL))
      ALU_ADD:   w_alu = w_sum[DW-1:0];
      ALU_AND:   w_alu = w_a & w_b;
      ALU_OR:    w_alu = w_a | w_b;
      ALU_XOR:   w_alu = w_a ^ w_b;
      ALU_SHL:   w_alu = w_a << w_b[4:0];
      ALU_SHR:   w_alu = w_a >> w_b[4:0];
      default:   w_alu = w_b;
    endcase
  end

  // A held FILTER instruction is ignored once the engine has left IDLE.
  assign w_filt  = (ALU_CTRL == ALU_FILT);
  assign w_idle  = (w_mst == ST_IDLE);
  assign w_start = w_idle & w_filt & !PROHIB_EXE;
  assign w_scal  = w_idle & !w_filt;
  assign w_arch  = w_scal & !PROHIB_EXE;

  assign stall_o     = !rst & (w_start | (w_mst == ST_RUN));
  assign br_taken_o  = salto & w_arch & cond_true(cond, r_flags);
  assign br_target_o = PCmas4 + (inmediato << 2);
  assign flags_o     = r_flags;

  exe_pixel_mac #(.DW(DW), .VW(VW), .LANES(LANES), .ACCW(ACCW)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_pix   (cuarenta),
    .i_coef  (inmediato),
    .o_state (w_mst),
    .o_res   (w_fres)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_arch) begin
      if (compara | we_c_aux) begin
        r_flags[FN] <= w_alu[DW-1];
        r_flags[FZ] <= (w_alu == '0);
      end
      if (we_c_aux) r_flags[FC] <= w_sum[DW];
      if (we_v)     r_flags[FV] <= w_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res_o <= '0;
      st_data_o <= '0;
      we_mem_o  <= 1'b0;
      sel_dat_o <= 1'b0;
      sel_res_o <= 1'b0;
      Rg_o      <= '0;
      valid_o   <= 1'b0;
    end else begin
      st_data_o <= w_b;
      sel_dat_o <= sel_dat;
      sel_res_o <= sel_res;
      Rg_o      <= Rg_exe;
      if (w_mst == ST_DONE) begin
        alu_res_o <= {{(DW-8){1'b0}}, w_fres};
        valid_o   <= 1'b1;
        we_mem_o  <= we_mem;
      end else if (w_scal) begin
        alu_res_o <= w_alu;
        valid_o   <= !PROHIB_EXE & !compara;
        we_mem_o  <= we_mem & !PROHIB_EXE & !compara;
      end else begin
        valid_o  <= 1'b0;
        we_mem_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cond;
  logic        we_mem, sel_dat, sel_res, sel_c, we_v, we_c_aux, compara, suma_resta, salto, PROHIB_EXE;
  logic [2:0]  ALU_CTRL;
  logic [1:0]  selOp_A, selOp_B;
  logic [31:0] PCmas4, DoA, DoB, inmediato, fwd_mem, fwd_wb;
  logic [39:0] cuarenta;
  logic [3:0]  Rg_exe;
  logic        stall_o, br_taken_o, we_mem_o, sel_dat_o, sel_res_o, valid_o;
  logic [31:0] br_target_o, alu_res_o, st_data_o;
  logic [3:0]  flags_o, Rg_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] mf;  // model flags {N,Z,C,V}

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .cond(cond), .we_mem(we_mem), .sel_dat(sel_dat), .sel_res(sel_res),
    .sel_c(sel_c), .we_v(we_v), .we_c_aux(we_c_aux), .compara(compara), .suma_resta(suma_resta),
    .salto(salto), .PROHIB_EXE(PROHIB_EXE), .ALU_CTRL(ALU_CTRL), .selOp_A(selOp_A), .selOp_B(selOp_B),
    .PCmas4(PCmas4), .DoA(DoA), .DoB(DoB), .inmediato(inmediato), .cuarenta(cuarenta), .Rg_exe(Rg_exe),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .stall_o(stall_o), .br_taken_o(br_taken_o),
    .br_target_o(br_target_o), .flags_o(flags_o), .alu_res_o(alu_res_o), .st_data_o(st_data_o),
    .we_mem_o(we_mem_o), .sel_dat_o(sel_dat_o), .sel_res_o(sel_res_o), .Rg_o(Rg_o), .valid_o(valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    {cond, we_mem, sel_dat, sel_res, sel_c, we_v, we_c_aux, compara, suma_resta, salto, PROHIB_EXE} = '0;
    ALU_CTRL = 3'd0; selOp_A = 2'd0; selOp_B = 2'd0;
    PCmas4 = 0; DoA = 0; DoB = 0; inmediato = 0; fwd_mem = 0; fwd_wb = 0; cuarenta = 0; Rg_exe = 0;
  endtask

  function automatic logic [31:0] mk_imm(input int k0, k1, k2, k3, k4, sh);
    return {2'(sh), 6'(k4), 6'(k3), 6'(k2), 6'(k1), 6'(k0)};
  endfunction

  // Drives nothing; inputs are already applied at a negedge. Ends at the next negedge.
  task automatic step_scalar(input string tag);
    logic [31:0] a, b, res;
    longint s, sv;
    logic c, v, sub, brx, cin;
    case (selOp_A) 0: a = DoA; 1: a = fwd_mem; 2: a = fwd_wb; default: a = PCmas4; endcase
    case (selOp_B) 0: b = DoB; 1: b = fwd_mem; 2: b = fwd_wb; default: b = inmediato; endcase
    sub = suma_resta | compara;
    if (!sub) begin
      cin = sel_c ? mf[1] : 1'b0;
      s  = longint'(a) + longint'(b) + longint'(cin);
      sv = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      c  = s[32];
    end else begin
      cin = sel_c ? !mf[1] : 1'b0;  // borrow in
      s  = longint'(a) - longint'(b) - longint'(cin);
      sv = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
      c  = (s >= 0);
    end
    v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    case (ALU_CTRL)
      0: res = s[31:0];
      1: res = a & b;
      2: res = a | b;
      3: res = a ^ b;
      4: res = a << b[4:0];
      5: res = a >> b[4:0];
      default: res = b;
    endcase
    brx = salto && !PROHIB_EXE && (cond == 0 || (cond == 1 && mf[2]) || (cond == 2 && !mf[2]) ||
                                   (cond == 3 && (mf[3] ^ mf[0])));
    #1;
    chk({tag, ".br"}, br_taken_o, brx);
    chk({tag, ".tgt"}, br_target_o, PCmas4 + inmediato * 4);
    chk({tag, ".stall"}, stall_o, 0);
    @(posedge clk);
    if (!PROHIB_EXE) begin
      if (compara || we_c_aux) begin mf[3] = res[31]; mf[2] = (res == 0); end
      if (we_c_aux) mf[1] = c;
      if (we_v) mf[0] = v;
    end
    #1;
    chk({tag, ".res"}, alu_res_o, res);
    chk({tag, ".valid"}, valid_o, !PROHIB_EXE && !compara);
    chk({tag, ".we"}, we_mem_o, we_mem && !PROHIB_EXE && !compara);
    chk({tag, ".flags"}, flags_o, mf);
    chk({tag, ".rg"}, {sel_dat_o, sel_res_o, Rg_o}, {sel_dat, sel_res, Rg_exe});
    chk({tag, ".st"}, st_data_o, b);
    @(negedge clk);
  endtask

  task automatic rand_scalar();
    ALU_CTRL = 3'($urandom_range(0, 6));
    selOp_A = 2'($urandom); selOp_B = 2'($urandom); cond = 2'($urandom);
    {we_mem, sel_dat, sel_res, sel_c, we_v, we_c_aux, suma_resta, salto} = 8'($urandom);
    compara = ($urandom_range(0, 5) == 0);
    PROHIB_EXE = ($urandom_range(0, 7) == 0);
    if (compara) ALU_CTRL = 3'd0;
    PCmas4 = $urandom; DoA = $urandom; inmediato = $urandom;
    fwd_mem = $urandom; fwd_wb = $urandom; Rg_exe = 4'($urandom);
    DoB = ($urandom_range(0, 3) == 0) ? DoA : $urandom;
  endtask

  // Holds a FILTER instruction through issue, RUN and DONE; ends at a negedge.
  task automatic run_filter(input string tag, input logic [39:0] pv, input logic [31:0] imm, input int want);
    int acc;
    clr_in();
    ALU_CTRL = 3'd7; cuarenta = pv; inmediato = imm;
    salto = 1'b1; we_v = 1'b1; we_c_aux = 1'b1; we_mem = 1'($urandom); Rg_exe = 4'($urandom);
    acc = 0;
    for (int i = 0; i < 5; i++) acc += int'(pv[8*i +: 8]) * int'($signed(imm[6*i +: 6]));
    acc = acc >>> imm[31:30];
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    if (want >= 0) chk({tag, ".model"}, 32'(acc), 32'(want));
    for (int cyc = 0; cyc < 7; cyc++) begin
      #1;
      chk($sformatf("%s.stall%0d", tag, cyc), stall_o, cyc < 6);
      chk($sformatf("%s.br%0d", tag, cyc), br_taken_o, 0);
      @(posedge clk); #1;
      if (cyc < 6) chk($sformatf("%s.vld%0d", tag, cyc), valid_o, 0);
      @(negedge clk);
    end
    chk({tag, ".res"}, alu_res_o, 32'(acc));
    chk({tag, ".valid"}, valid_o, 1);
    chk({tag, ".we"}, we_mem_o, we_mem);
    chk({tag, ".flags"}, flags_o, mf);
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    mf = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst.res", alu_res_o, 0);
    chk("rst.valid", valid_o, 0);
    chk("rst.flags", flags_o, 0);
    chk("rst.stall", stall_o, 0);
    rst = 1'b0;
    @(negedge clk);

    DoA = 32'h7FFF_FFFF; DoB = 32'd1; we_v = 1'b1; we_c_aux = 1'b1;
    step_scalar("add_ovf");
    chk("add_ovf.k", alu_res_o, 32'h8000_0000);
    chk("add_ovf.kf", flags_o, 4'b1001);

    clr_in(); selOp_A = 2'd1; fwd_mem = 5; selOp_B = 2'd2; fwd_wb = 3; suma_resta = 1'b1;
    step_scalar("fwd_sub");
    chk("fwd_sub.k", alu_res_o, 32'd2);

    clr_in(); compara = 1'b1; DoA = 32'd9; DoB = 32'd9;
    step_scalar("cmp");
    chk("cmp.kz", flags_o[2], 1);
    chk("cmp.kv", valid_o, 0);

    clr_in(); ALU_CTRL = 3'd6; salto = 1'b1; cond = 2'b01; PCmas4 = 32'h100; inmediato = 32'd4;
    #1;
    chk("beq.k", br_taken_o, 1);
    chk("beq.kt", br_target_o, 32'h110);
    step_scalar("beq");
    PROHIB_EXE = 1'b1;
    #1;
    chk("beq_pro.k", br_taken_o, 0);
    step_scalar("beq_pro");

    run_filter("f125", {5{8'd100}}, mk_imm(1, 2, 4, 2, 1, 3), 125);
    run_filter("f255", {5{8'd255}}, mk_imm(31, 31, 31, 31, 31, 0), 255);
    run_filter("f0",   {5{8'd255}}, mk_imm(-1, -1, -1, -1, -1, 0), 0);

    // Abort a filter in its third RUN cycle.
    clr_in(); ALU_CTRL = 3'd7; cuarenta = {5{8'd100}}; inmediato = mk_imm(1, 2, 4, 2, 1, 3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.stall", stall_o, 0);
    chk("abort.res", alu_res_o, 0);
    chk("abort.valid", valid_o, 0);
    chk("abort.flags", flags_o, 0);
    mf = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    run_filter("after_abort", {5{8'd100}}, mk_imm(1, 2, 4, 2, 1, 3), 125);

    // Back-to-back: the ADD lands one edge after the filter result.
    clr_in(); DoA = 32'd40; DoB = 32'd2;
    step_scalar("b2b_add");
    chk("b2b_add.k", alu_res_o, 32'd42);
    rand_scalar();
    step_scalar("b2b_next");

    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 5) begin
        run_filter($sformatf("rf%0d", i), {8'($urandom), 32'($urandom)}, $urandom, -1);
      end else begin
        rand_scalar();
        step_scalar($sformatf("rs%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
